// File: rtl/ifetch_unit_pkg.sv
// ifetch_unit_pkg: shared widths, fetch state encoding and PC helpers for the fetch stage.
package ifetch_unit_pkg;

  localparam int DEF_ISA_WIDTH = 32;
  localparam int PC_STEP       = 4;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_IO_WAIT = 2'd1,
    ST_FAULT   = 2'd2
  } fetch_state_t;

  // A fetch target must sit on a 32-bit word boundary.
  function automatic logic word_aligned(input logic [1:0] low_bits);
    return low_bits == 2'b00;
  endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// ifetch_unit_if: ROM read port plus the fetch/decode handshake and redirect controls.
interface ifetch_unit_if
  import ifetch_unit_pkg::*;
#(
  parameter int ISA_WIDTH      = DEF_ISA_WIDTH,
  parameter int ROM_ADDR_WIDTH = 14
);

  logic [ROM_ADDR_WIDTH-1:0] rom_addr;
  logic [ISA_WIDTH-1:0]      rom_data;
  logic [ISA_WIDTH-1:0]      instruction;
  logic [ISA_WIDTH-1:0]      inst_pc;
  logic [ISA_WIDTH-1:0]      pc_plus4;
  logic                      inst_valid;
  logic                      id_ready;
  logic                      branch;
  logic                      nbranch;
  logic                      zero;
  logic                      jmp;
  logic                      jal;
  logic                      jr;
  logic [ISA_WIDTH-1:0]      addr_result;
  logic [ISA_WIDTH-1:0]      read_data_1;

  // The fetch unit drives the ROM address and the instruction towards decode.
  modport master (
    output rom_addr, instruction, inst_pc, pc_plus4, inst_valid,
    input  rom_data, id_ready, branch, nbranch, zero, jmp, jal, jr,
           addr_result, read_data_1
  );

  // The ROM and the rest of the core sit on the other side.
  modport slave (
    input  rom_addr, instruction, inst_pc, pc_plus4, inst_valid,
    output rom_data, id_ready, branch, nbranch, zero, jmp, jal, jr,
           addr_result, read_data_1
  );

endinterface

// File: rtl/ifetch_unit_perf_counters.sv
// ifetch_perf_counters: four free-running wrap-around event counters with a shared clear.
module ifetch_perf_counters #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 perf_clear,
  input  logic                 ret_inc,
  input  logic                 redir_inc,
  input  logic                 stall_inc,
  output logic [CNT_WIDTH-1:0] cyc_cnt,
  output logic [CNT_WIDTH-1:0] ret_cnt,
  output logic [CNT_WIDTH-1:0] redir_cnt,
  output logic [CNT_WIDTH-1:0] stall_cnt
);

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  // Clear wins over any same-cycle event; otherwise each counter adds its event and wraps.
  always_ff @(posedge clock) begin
    if (reset || perf_clear) begin
      cyc_cnt   <= '0;
      ret_cnt   <= '0;
      redir_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + ONE;
      if (ret_inc)   ret_cnt   <= ret_cnt + ONE;
      if (redir_inc) redir_cnt <= redir_cnt + ONE;
      if (stall_inc) stall_cnt <= stall_cnt + ONE;
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: owns the PC, addresses the sync ROM with the next PC so redirects cost no
// bubble, stalls on decode back-pressure or pending IO reads, and traps illegal targets.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter int                   ISA_WIDTH      = DEF_ISA_WIDTH,
  parameter int                   JADDR_WIDTH    = 26,
  parameter int                   ROM_ADDR_WIDTH = 14,
  parameter logic [ISA_WIDTH-1:0] RESET_PC       = '0,
  parameter int                   CNT_WIDTH      = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  ifetch_unit_if.master        bus,
  input  logic                 io_read,
  input  logic                 confirm_button,
  output logic [ISA_WIDTH-1:0] link_addr,
  output logic                 io_waiting,
  output logic                 fault,
  output logic [ISA_WIDTH-1:0] fault_pc,
  input  logic                 perf_clear,
  output logic [CNT_WIDTH-1:0] cyc_cnt,
  output logic [CNT_WIDTH-1:0] ret_cnt,
  output logic [CNT_WIDTH-1:0] redir_cnt,
  output logic [CNT_WIDTH-1:0] stall_cnt
);

  localparam logic [ISA_WIDTH-1:0]      STEP       = ISA_WIDTH'(PC_STEP);
  localparam logic [ISA_WIDTH-1:0]      JMASK      = (ISA_WIDTH'(1) << (JADDR_WIDTH + 2)) - STEP;
  localparam logic [ROM_ADDR_WIDTH-1:0] RESET_WORD = RESET_PC[ROM_ADDR_WIDTH+1:2];

  fetch_state_t         state_q, state_d;
  logic [ISA_WIDTH-1:0] pc_q, pc_d;
  logic [ISA_WIDTH-1:0] pc_plus4, inst_word, jump_target, target;
  logic                 inst_valid, io_hold, accept, take_branch, target_illegal, redirect;

  assign pc_plus4    = pc_q + STEP;
  assign inst_valid  = (state_q != ST_FAULT) && !reset;
  assign inst_word   = inst_valid ? bus.rom_data : '0;
  assign io_hold     = io_read && !confirm_button;
  assign accept      = inst_valid && bus.id_ready && !io_hold;
  assign take_branch = (bus.branch && bus.zero) || (bus.nbranch && !bus.zero);
  assign jump_target = (pc_plus4 & ~JMASK) | ((inst_word << 2) & JMASK);

  // Pick the fetch target by priority: jumps, then jr, then a taken branch, else sequential.
  always_comb begin
    target = pc_plus4;
    if (bus.jmp || bus.jal) target = jump_target;
    else if (bus.jr)        target = bus.read_data_1;
    else if (take_branch)   target = bus.addr_result;
  end

  assign target_illegal = !word_aligned(target[1:0]) ||
                          (target[ISA_WIDTH-1:ROM_ADDR_WIDTH+2] != '0);
  assign redirect       = accept && !target_illegal && (target != pc_plus4);

  // The ROM sees the PC that will be current next cycle, so its data lines up with it.
  assign bus.rom_addr = reset  ? RESET_WORD :
                        accept ? target[ROM_ADDR_WIDTH+1:2] : pc_q[ROM_ADDR_WIDTH+1:2];

  assign bus.instruction = inst_word;
  assign bus.inst_pc     = pc_q;
  assign bus.pc_plus4    = pc_plus4;
  assign bus.inst_valid  = inst_valid;
  assign io_waiting      = (state_q == ST_IO_WAIT);
  assign fault           = (state_q == ST_FAULT);

  // Next state and next PC: advance on accept, trap on an illegal target, park on IO reads.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      ST_RUN: begin
        if (accept) begin
          if (target_illegal) state_d = ST_FAULT;
          else                pc_d    = target;
        end else if (io_hold) begin
          state_d = ST_IO_WAIT;
        end
      end
      ST_IO_WAIT: begin
        if (accept) begin
          if (target_illegal) begin
            state_d = ST_FAULT;
          end else begin
            pc_d    = target;
            state_d = ST_RUN;
          end
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State, PC, link register and trap address registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_RUN;
      pc_q      <= RESET_PC;
      link_addr <= '0;
      fault_pc  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (accept && bus.jal)        link_addr <= pc_plus4;
      if (accept && target_illegal) fault_pc  <= pc_q;
    end
  end

  ifetch_perf_counters #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_perf (
    .clock     (clock),
    .reset     (reset),
    .perf_clear(perf_clear),
    .ret_inc   (accept),
    .redir_inc (redirect),
    .stall_inc (inst_valid && !accept),
    .cyc_cnt   (cyc_cnt),
    .ret_cnt   (ret_cnt),
    .redir_cnt (redir_cnt),
    .stall_cnt (stall_cnt)
  );

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: scoreboard bench; expected fetch PCs are queued as stimulus is driven and
// popped when the fetch stage presents the instruction.
module tb_ifetch_unit;

  localparam int          ISA_WIDTH      = 32;
  localparam int          JADDR_WIDTH    = 26;
  localparam int          ROM_ADDR_WIDTH = 7;
  localparam int          CNT_WIDTH      = 4;
  localparam logic [31:0] RESET_PC       = 32'h40;

  logic                 clock, reset, io_read, confirm_button, perf_clear;
  logic                 io_waiting, fault;
  logic [31:0]          link_addr, fault_pc;
  logic [CNT_WIDTH-1:0] cyc_cnt, ret_cnt, redir_cnt, stall_cnt;

  int          tests  = 0;
  int          errors = 0;
  logic [31:0] exp_pc_q[$];
  logic [31:0] rom_mem [0:127];

  ifetch_unit_if #(.ISA_WIDTH(ISA_WIDTH), .ROM_ADDR_WIDTH(ROM_ADDR_WIDTH)) bus ();

  ifetch_unit #(
    .ISA_WIDTH(ISA_WIDTH), .JADDR_WIDTH(JADDR_WIDTH), .ROM_ADDR_WIDTH(ROM_ADDR_WIDTH),
    .RESET_PC(RESET_PC), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus), .io_read(io_read),
    .confirm_button(confirm_button), .link_addr(link_addr), .io_waiting(io_waiting),
    .fault(fault), .fault_pc(fault_pc), .perf_clear(perf_clear), .cyc_cnt(cyc_cnt),
    .ret_cnt(ret_cnt), .redir_cnt(redir_cnt), .stall_cnt(stall_cnt)
  );

  // Free-running clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous ROM model with one cycle of read latency.
  always @(posedge clock) bus.rom_data <= rom_mem[bus.rom_addr];

  function automatic logic [31:0] rom_word(input logic [31:0] pc);
    return rom_mem[pc[8:2]];
  endfunction

  task automatic drive_idle();
    bus.id_ready = 1'b1; bus.branch = 1'b0; bus.nbranch = 1'b0; bus.zero = 1'b0;
    bus.jmp = 1'b0; bus.jal = 1'b0; bus.jr = 1'b0;
    bus.addr_result = '0; bus.read_data_1 = '0;
    io_read = 1'b0; confirm_button = 1'b0; perf_clear = 1'b0;
  endtask

  // Redirect with jr to addr and clear the counters on that same accept.
  task automatic jump_to(input logic [31:0] addr);
    bus.jr = 1'b1; bus.read_data_1 = addr; perf_clear = 1'b1;
    exp_pc_q.push_back(addr);
    @(negedge clock);
    bus.jr = 1'b0; perf_clear = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    drive_idle();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    tests++;
    if (bus.inst_valid !== 1'b0 || bus.instruction !== 32'h0 || bus.rom_addr !== 7'h10) begin
      errors++;
      $display("[TB] FAIL reset_outputs: valid=%b instr=%h rom_addr=%h, want 0/0/10",
               bus.inst_valid, bus.instruction, bus.rom_addr);
    end
    tests++;
    if (cyc_cnt !== 0 || ret_cnt !== 0 || fault !== 0 || link_addr !== 0 || io_waiting !== 0) begin
      errors++;
      $display("[TB] FAIL reset_state: cyc=%0d ret=%0d fault=%b link=%h iow=%b, want all 0",
               cyc_cnt, ret_cnt, fault, link_addr, io_waiting);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) exp_pc_q.push_back(RESET_PC + 32'(4 * i));
    for (int i = 0; i < 3; i++) begin
      #1;
      exp = exp_pc_q.pop_front();
      tests++;
      if (bus.inst_pc !== exp || bus.instruction !== rom_word(exp) || bus.inst_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL reset_seq%0d: pc=%h instr=%h valid=%b, want pc=%h instr=%h valid=1",
                 i, bus.inst_pc, bus.instruction, bus.inst_valid, exp, rom_word(exp));
      end
      @(negedge clock);
    end
    #1;
    tests++;
    if (ret_cnt !== 4'd3 || cyc_cnt !== 4'd3) begin
      errors++;
      $display("[TB] FAIL reset_counts: ret=%0d cyc=%0d, want 3/3", ret_cnt, cyc_cnt);
    end
  endtask

  task automatic test_branch();
    logic [31:0] exp;
    // bne with zero=1 falls through
    jump_to(32'h8);
    #1; exp = exp_pc_q.pop_front();
    tests++;
    if (bus.inst_pc !== exp) begin
      errors++; $display("[TB] FAIL bne_base: pc=%h want %h", bus.inst_pc, exp);
    end
    bus.nbranch = 1'b1; bus.zero = 1'b1; bus.addr_result = 32'h200;
    exp_pc_q.push_back(32'hC);
    @(negedge clock); drive_idle();
    #1; exp = exp_pc_q.pop_front();
    tests++;
    if (bus.inst_pc !== exp || bus.instruction !== rom_word(exp) || redir_cnt !== 0 || ret_cnt !== 1) begin
      errors++;
      $display("[TB] FAIL bne_not_taken: pc=%h instr=%h redir=%0d ret=%0d, want pc=%h instr=%h redir=0 ret=1",
               bus.inst_pc, bus.instruction, redir_cnt, ret_cnt, exp, rom_word(exp));
    end
    // beq taken
    jump_to(32'h8);
    #1; void'(exp_pc_q.pop_front());
    bus.branch = 1'b1; bus.zero = 1'b1; bus.addr_result = 32'h100;
    exp_pc_q.push_back(32'h100);
    @(negedge clock); drive_idle();
    #1; exp = exp_pc_q.pop_front();
    tests++;
    if (bus.inst_pc !== exp || bus.instruction !== rom_word(exp) || bus.inst_valid !== 1'b1 ||
        redir_cnt !== 1 || stall_cnt !== 0) begin
      errors++;
      $display("[TB] FAIL beq_taken: pc=%h instr=%h valid=%b redir=%0d stall=%0d, want pc=%h instr=%h valid=1 redir=1 stall=0",
               bus.inst_pc, bus.instruction, bus.inst_valid, redir_cnt, stall_cnt, exp, rom_word(exp));
    end
    // bne taken with zero=0
    bus.nbranch = 1'b1; bus.zero = 1'b0; bus.addr_result = 32'h20;
    exp_pc_q.push_back(32'h20);
    @(negedge clock); drive_idle();
    #1; exp = exp_pc_q.pop_front();
    tests++;
    if (bus.inst_pc !== exp || redir_cnt !== 2 || ret_cnt !== 2) begin
      errors++;
      $display("[TB] FAIL bne_taken: pc=%h redir=%0d ret=%0d, want pc=%h redir=2 ret=2",
               bus.inst_pc, redir_cnt, ret_cnt, exp);
    end
  endtask

  task automatic test_jump();
    logic [31:0] exp;
    jump_to(32'h10);
    #1; exp = exp_pc_q.pop_front();
    tests++;
    if (bus.inst_pc !== exp || bus.instruction !== 32'h0C00_0040) begin
      errors++;
      $display("[TB] FAIL jal_base: pc=%h instr=%h, want %h/0c000040", bus.inst_pc, bus.instruction, exp);
    end
    bus.jal = 1'b1;
    exp_pc_q.push_back(32'h100);
    @(negedge clock); drive_idle();
    #1; exp = exp_pc_q.pop_front();
    tests++;
    if (bus.inst_pc !== exp || link_addr !== 32'h14 || redir_cnt !== 1) begin
      errors++;
      $display("[TB] FAIL jal_target: pc=%h link=%h redir=%0d, want pc=%h link=14 redir=1",
               bus.inst_pc, link_addr, redir_cnt, exp);
    end
    bus.jr = 1'b1; bus.read_data_1 = 32'h14;
    exp_pc_q.push_back(32'h14);
    @(negedge clock); drive_idle();
    #1; exp = exp_pc_q.pop_front();
    tests++;
    if (bus.inst_pc !== exp || bus.instruction !== rom_word(exp)) begin
      errors++;
      $display("[TB] FAIL jr_target: pc=%h instr=%h, want pc=%h instr=%h",
               bus.inst_pc, bus.instruction, exp, rom_word(exp));
    end
    // plain j from pc 0 with a zero immediate lands on 0 and leaves the link register alone
    jump_to(32'h0);
    #1; void'(exp_pc_q.pop_front());
    bus.jmp = 1'b1;
    exp_pc_q.push_back(32'h0);
    @(negedge clock); drive_idle();
    #1; exp = exp_pc_q.pop_front();
    tests++;
    if (bus.inst_pc !== exp || link_addr !== 32'h14 || redir_cnt !== 1) begin
      errors++;
      $display("[TB] FAIL j_target: pc=%h link=%h redir=%0d, want pc=%h link=14 redir=1",
               bus.inst_pc, link_addr, redir_cnt, exp);
    end
  endtask

  task automatic test_io_wait();
    logic [31:0] exp;
    jump_to(32'h20);
    #1; void'(exp_pc_q.pop_front());
    io_read = 1'b1; confirm_button = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock); #1;
      tests++;
      if (bus.inst_pc !== 32'h20 || io_waiting !== 1'b1 || bus.instruction !== rom_word(32'h20)) begin
        errors++;
        $display("[TB] FAIL io_hold%0d: pc=%h iow=%b instr=%h, want pc=20 iow=1 instr=%h",
                 i, bus.inst_pc, io_waiting, bus.instruction, rom_word(32'h20));
      end
    end
    tests++;
    if (stall_cnt !== 4'd5 || ret_cnt !== 4'd0) begin
      errors++; $display("[TB] FAIL io_stall_cnt: stall=%0d ret=%0d, want 5/0", stall_cnt, ret_cnt);
    end
    confirm_button = 1'b1;
    exp_pc_q.push_back(32'h24);
    @(negedge clock); drive_idle();
    #1; exp = exp_pc_q.pop_front();
    tests++;
    if (bus.inst_pc !== exp || io_waiting !== 1'b0 || ret_cnt !== 4'd1 || stall_cnt !== 4'd5) begin
      errors++;
      $display("[TB] FAIL io_confirm: pc=%h iow=%b ret=%0d stall=%0d, want pc=%h iow=0 ret=1 stall=5",
               bus.inst_pc, io_waiting, ret_cnt, stall_cnt, exp);
    end
    // reset while parked in IO_WAIT
    io_read = 1'b1;
    @(negedge clock);
    reset = 1'b1; io_read = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    exp_pc_q.push_back(RESET_PC);
    #1; exp = exp_pc_q.pop_front();
    tests++;
    if (bus.inst_pc !== exp || io_waiting !== 1'b0 || bus.inst_valid !== 1'b1 || cyc_cnt !== 0) begin
      errors++;
      $display("[TB] FAIL io_reset: pc=%h iow=%b valid=%b cyc=%0d, want pc=%h iow=0 valid=1 cyc=0",
               bus.inst_pc, io_waiting, bus.inst_valid, cyc_cnt, exp);
    end
  endtask

  task automatic test_id_stall();
    logic [31:0] exp;
    jump_to(32'h30);
    #1; void'(exp_pc_q.pop_front());
    bus.id_ready = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    tests++;
    if (bus.inst_pc !== 32'h30 || bus.instruction !== rom_word(32'h30) || stall_cnt !== 3 || ret_cnt !== 0) begin
      errors++;
      $display("[TB] FAIL id_stall: pc=%h instr=%h stall=%0d ret=%0d, want pc=30 instr=%h stall=3 ret=0",
               bus.inst_pc, bus.instruction, stall_cnt, ret_cnt, rom_word(32'h30));
    end
    bus.id_ready = 1'b1;
    exp_pc_q.push_back(32'h34);
    @(negedge clock);
    #1; exp = exp_pc_q.pop_front();
    tests++;
    if (bus.inst_pc !== exp || bus.instruction !== rom_word(exp)) begin
      errors++;
      $display("[TB] FAIL id_release: pc=%h instr=%h, want %h/%h", bus.inst_pc, bus.instruction, exp, rom_word(exp));
    end
  endtask

  task automatic test_fault();
    logic [31:0] exp;
    // misaligned jr target
    jump_to(32'h30);
    #1; void'(exp_pc_q.pop_front());
    bus.jr = 1'b1; bus.read_data_1 = 32'h102;
    @(negedge clock); drive_idle();
    #1;
    tests++;
    if (fault !== 1'b1 || fault_pc !== 32'h30 || bus.inst_valid !== 1'b0 || bus.instruction !== 0 ||
        ret_cnt !== 1 || redir_cnt !== 0) begin
      errors++;
      $display("[TB] FAIL jr_fault: fault=%b fpc=%h valid=%b instr=%h ret=%0d redir=%0d, want 1/30/0/0/1/0",
               fault, fault_pc, bus.inst_valid, bus.instruction, ret_cnt, redir_cnt);
    end
    repeat (3) @(negedge clock);
    #1;
    tests++;
    if (fault !== 1'b1 || bus.inst_valid !== 1'b0 || bus.inst_pc !== 32'h30 || stall_cnt !== 0 || cyc_cnt !== 4) begin
      errors++;
      $display("[TB] FAIL fault_hold: fault=%b valid=%b pc=%h stall=%0d cyc=%0d, want 1/0/30/0/4",
               fault, bus.inst_valid, bus.inst_pc, stall_cnt, cyc_cnt);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    exp_pc_q.push_back(RESET_PC);
    #1; exp = exp_pc_q.pop_front();
    tests++;
    if (fault !== 1'b0 || fault_pc !== 0 || bus.inst_pc !== exp || bus.inst_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL fault_reset: fault=%b fpc=%h pc=%h valid=%b, want 0/0/%h/1",
               fault, fault_pc, bus.inst_pc, bus.inst_valid, exp);
    end
    // sequential run-off past the last ROM word
    jump_to(32'h1FC);
    #1; exp = exp_pc_q.pop_front();
    tests++;
    if (bus.inst_pc !== exp || bus.instruction !== rom_word(exp) || fault !== 1'b0) begin
      errors++;
      $display("[TB] FAIL last_word: pc=%h instr=%h fault=%b, want %h/%h/0",
               bus.inst_pc, bus.instruction, fault, exp, rom_word(exp));
    end
    @(negedge clock);
    #1;
    tests++;
    if (fault !== 1'b1 || fault_pc !== 32'h1FC || bus.inst_valid !== 1'b0 || bus.inst_pc !== 32'h1FC) begin
      errors++;
      $display("[TB] FAIL runoff_fault: fault=%b fpc=%h valid=%b pc=%h, want 1/1fc/0/1fc",
               fault, fault_pc, bus.inst_valid, bus.inst_pc);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_perf_wrap();
    logic [31:0] exp;
    jump_to(32'h0);
    #1; void'(exp_pc_q.pop_front());
    for (int i = 1; i <= 17; i++) begin
      exp_pc_q.push_back(32'(4 * i));
      @(negedge clock);
      #1; exp = exp_pc_q.pop_front();
      tests++;
      if (bus.inst_pc !== exp || bus.instruction !== rom_word(exp)) begin
        errors++;
        $display("[TB] FAIL wrap_seq%0d: pc=%h instr=%h, want %h/%h",
                 i, bus.inst_pc, bus.instruction, exp, rom_word(exp));
      end
    end
    tests++;
    if (ret_cnt !== 4'd1 || cyc_cnt !== 4'd1) begin
      errors++; $display("[TB] FAIL ret_wrap: ret=%0d cyc=%0d, want 1/1", ret_cnt, cyc_cnt);
    end
    perf_clear = 1'b1;
    exp_pc_q.push_back(32'h48);
    @(negedge clock); perf_clear = 1'b0;
    #1; exp = exp_pc_q.pop_front();
    tests++;
    if (bus.inst_pc !== exp || ret_cnt !== 0 || cyc_cnt !== 0 || stall_cnt !== 0) begin
      errors++;
      $display("[TB] FAIL clear_vs_accept: pc=%h ret=%0d cyc=%0d stall=%0d, want pc=%h 0/0/0",
               bus.inst_pc, ret_cnt, cyc_cnt, stall_cnt, exp);
    end
  endtask

  // Bound the whole run in case the design wedges.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, errors);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < 128; i++) rom_mem[i] = 32'(i);
    rom_mem[4] = 32'h0C00_0040;
    reset = 1'b1;
    drive_idle();
    test_reset();
    test_branch();
    test_jump();
    test_io_wait();
    test_id_stall();
    test_fault();
    test_perf_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
